mips_cpu_pc_unit: RTL and testbench
===================================

// Module: mips_cpu_pc_unit
// PURPOSE
//  - Program-counter/fetch-address stage of mips_cpu_harvard; drives instr_address to instruction memory.
//  - Applies taken branch/jump redirects from decode with one architectural delay slot.
//  - Computes branch/jump targets and the link address.
//  - Signals end of program: on a jump to HALT_ADDR, active drops once the delay slot has issued.
// PARAMETERS
//  RESET_VECTOR  32'hBFC00000  fetch address after reset
//  HALT_ADDR     32'h00000000  redirect target that halts the CPU
// PORTS
//  clk             in   1   rising-edge clock
//  reset           in   1   synchronous, active-high reset
//  clk_enable      in   1   global advance enable; 0 freezes all state
//  redirect_kind   in   2   redirect_kind_t: NONE/BRANCH/JUMP/JUMP_REG for the instr at instr_address, taken only
//  branch_imm      in   16  branch offset field (words, signed)
//  jump_index      in   26  J/JAL instr_index field
//  jr_target       in   32  rs value for JR/JALR
//  instr_address   out  32  current fetch PC
//  link_addr       out  32  instr_address+8 (comb), return address for JAL/JALR/BGEZAL
//  active          out  1   1 while running, 0 once halted
//  addr_fault      out  1   misaligned redirect target seen (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (sync, active-high; one cycle suffices, overrides clk_enable):
//    instr_address=RESET_VECTOR, state=RUN, pending_target=0, active=1, addr_fault=0.
//  - clk_enable=0: all registers hold; outputs stable.
//  - FSM pc_state_t {RUN, DELAY, HALTED}; one transition per enabled rising edge:
//    - RUN, kind=NONE: pc<=pc+4.
//    - RUN, kind!=NONE: pending_target<=target; pc<=pc+4 (delay slot); ->DELAY.
//    - DELAY: pc<=pending_target; ->HALTED if pending_target==HALT_ADDR, else ->RUN.
//      redirect_kind is ignored in DELAY (branch in delay slot: no effect).
//    - HALTED: pc holds HALT_ADDR, active=0; leaves only via reset.
//  - active is registered; it falls on the same edge that pc becomes HALT_ADDR.
//  - Target arithmetic (base = pc+4, 32-bit wrap, no overflow detection):
//    - BRANCH:   base + {{14{imm[15]}},imm,2'b00}.
//    - JUMP:     {base[31:28], jump_index, 2'b00}.
//    - JUMP_REG: jr_target.
//  - Wrap: pc=32'hFFFFFFFC, NONE -> 32'h00000000; this is not a halt (halt only via redirect).
//  - Reset mid-DELAY: pending redirect discarded; fetch restarts at RESET_VECTOR.
// CONFIGURATION
//  - PC_ALIGN_CHECK_EN defined:
//    - target[1:0]!=0 on a redirect in RUN: addr_fault<=1 and ->HALTED.
//    - The delay slot is not issued; pc<=HALT_ADDR, active<=0.
//  - Undefined: target[1:0] forced to 2'b00, addr_fault tied 0.
// STRUCTURE
//  - Package mips_pc_pkg:
//    - redirect_kind_t (2-bit enum), pc_state_t enum.
//    - Constants PC_STEP=4, DEFAULT_RESET_VECTOR.
//  - Sub-module mips_pc_target_calc: purely combinational target/link computation.
//  - mips_cpu_pc_unit holds the FSM and registers.
// TESTING
//  1. Reset, then 3 enabled cycles of NONE
//     -> instr_address BFC00000, BFC00004, BFC00008, BFC0000C; active=1.
//  2. At BFC00008: BRANCH imm=16'h0003
//     -> BFC0000C (slot), then BFC00018; link_addr at BFC00008 = BFC00010.
//  3. At BFC0002C: JUMP_REG jr_target=0
//     -> BFC00030 (slot, active=1), then instr_address=0 with active=0; stays there 5+ cycles.
//  4. At 3FFFFFF0: BRANCH imm=16'hFFFC
//     -> slot 3FFFFFF4, then 3FFFFFE4.
//     At BFC00000: JUMP idx=26'h0000010 -> BFC00004, then B0000040.
//  5. clk_enable=0 for 4 cycles while in DELAY -> pc frozen; redirect still applied on the next enabled edge.
//     reset during DELAY -> BFC00000, redirect lost.
//  6. JUMP_REG jr_target=BFC00022:
//     - with PC_ALIGN_CHECK_EN: addr_fault=1, active=0, pc=0 next edge.
//     - without: slot, then BFC00020.

Source files
------------

// File: rtl/mips_pc_pkg.sv
// ----------------------------------------------------------------------------
// mips_pc_pkg
// Shared types and constants for the program-counter / fetch-address stage.
//   redirect_kind_t : kind of taken control transfer reported by decode
//   pc_state_t      : PC sequencing state (running, delay slot, halted)
//   PC_STEP         : byte distance between sequential instructions
//   DEFAULT_*       : default reset vector and halt address
//   branch_offset() : sign-extended, word-scaled branch displacement
// ----------------------------------------------------------------------------
package mips_pc_pkg;

  typedef enum logic [1:0] {
    KIND_NONE     = 2'd0,
    KIND_BRANCH   = 2'd1,
    KIND_JUMP     = 2'd2,
    KIND_JUMP_REG = 2'd3
  } redirect_kind_t;

  typedef enum logic [1:0] {
    PC_RUN    = 2'd0,
    PC_DELAY  = 2'd1,
    PC_HALTED = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_STEP              = 32'd4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC0_0000;
  localparam logic [31:0] DEFAULT_HALT_ADDR    = 32'h0000_0000;

  // The 16-bit offset counts words; sign-extend and scale to bytes.
  function automatic logic [31:0] branch_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/mips_pc_target_calc.sv
// ----------------------------------------------------------------------------
// mips_pc_target_calc
// Purely combinational redirect-target and link-address computation.
// All arithmetic is relative to base = pc + 4 (the delay-slot address) and
// wraps modulo 2^32.
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : target passed through unmodified; misaligned flags low bits
//   undefined : target[1:0] forced to 2'b00
// Ports:
//   pc                in  32  current fetch address
//   redirect_kind     in  2   redirect_kind_t encoding
//   branch_imm        in  16  branch offset in words (signed)
//   jump_index        in  26  J/JAL instr_index field
//   jr_target         in  32  register target for JR/JALR
//   target            out 32  redirect destination
//   link_addr         out 32  return address (pc + 8)
//   target_misaligned out 1   raw target has nonzero low bits
// ----------------------------------------------------------------------------
module mips_pc_target_calc
  import mips_pc_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [1:0]  redirect_kind,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] target,
  output logic [31:0] link_addr,
  output logic        target_misaligned
);

  logic [31:0] base_s;
  logic [31:0] target_raw_s;

  // Raw target selection by redirect kind.
  always_comb begin
    base_s       = pc + PC_STEP;
    target_raw_s = base_s;
    case (redirect_kind_t'(redirect_kind))
      KIND_NONE:     target_raw_s = base_s;
      KIND_BRANCH:   target_raw_s = base_s + branch_offset(branch_imm);
      KIND_JUMP:     target_raw_s = {base_s[31:28], jump_index, 2'b00};
      KIND_JUMP_REG: target_raw_s = jr_target;
      default:       target_raw_s = base_s;
    endcase
  end

  // Only a register target can carry nonzero low bits.
  assign target_misaligned = (target_raw_s[1:0] != 2'b00);

`ifdef PC_ALIGN_CHECK_EN
  // Misaligned targets are trapped by the FSM, so pass the raw value on.
  assign target = target_raw_s;
`else
  // Without trapping, silently word-align every target.
  assign target = target_raw_s & 32'hFFFF_FFFC;
`endif

  // Return address skips the branch and its delay slot.
  assign link_addr = pc + (PC_STEP << 1);

endmodule

// File: rtl/mips_cpu_pc_unit.sv
// ----------------------------------------------------------------------------
// mips_cpu_pc_unit
// Program-counter / fetch-address stage. Sequences the fetch PC, applies
// taken redirects after one architectural delay slot, and stops the CPU once
// a redirect to HALT_ADDR has taken effect.
// Optional feature macro: PC_ALIGN_CHECK_EN
//   defined   : a misaligned redirect target sets addr_fault and halts
//               immediately (delay slot not issued)
//   undefined : targets word-aligned, addr_fault tied low
// Ports:
//   clk            in  1   rising-edge clock
//   reset          in  1   synchronous active-high reset (overrides clk_enable)
//   clk_enable     in  1   global advance enable; 0 freezes all state
//   redirect_kind  in  2   taken redirect for the instruction at instr_address
//   branch_imm     in  16  branch offset (words, signed)
//   jump_index     in  26  J/JAL instr_index
//   jr_target      in  32  JR/JALR register target
//   instr_address  out 32  current fetch PC (registered)
//   link_addr      out 32  instr_address + 8 (combinational)
//   active         out 1   high while running, low once halted (registered)
//   addr_fault     out 1   misaligned redirect target seen (registered)
// ----------------------------------------------------------------------------
module mips_cpu_pc_unit
  import mips_pc_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
  parameter logic [31:0] HALT_ADDR    = DEFAULT_HALT_ADDR
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic [1:0]  redirect_kind,
  input  logic [15:0] branch_imm,
  input  logic [25:0] jump_index,
  input  logic [31:0] jr_target,
  output logic [31:0] instr_address,
  output logic [31:0] link_addr,
  output logic        active,
  output logic        addr_fault
);

  pc_state_t   state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] pending_q, pending_d;
  logic        active_q, active_d;
  logic        addr_fault_q, addr_fault_d;

  logic [31:0] target_s;
  logic        misaligned_s;

  mips_pc_target_calc u_target_calc (
    .pc                (pc_q),
    .redirect_kind     (redirect_kind),
    .branch_imm        (branch_imm),
    .jump_index        (jump_index),
    .jr_target         (jr_target),
    .target            (target_s),
    .link_addr         (link_addr),
    .target_misaligned (misaligned_s)
  );

`ifndef PC_ALIGN_CHECK_EN
  // Alignment flag has no consumer when trapping is disabled.
  logic align_unused_s;
  assign align_unused_s = misaligned_s;
`endif

  // Next-state and next-PC selection for one enabled clock edge.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pending_d    = pending_q;
    active_d     = active_q;
    addr_fault_d = addr_fault_q;
    if (clk_enable) begin
      case (state_q)
        PC_RUN: begin
          if (redirect_kind_t'(redirect_kind) == KIND_NONE) begin
            // Sequential fetch; wraps past the top of memory without halting.
            pc_d = pc_q + PC_STEP;
          end else begin
`ifdef PC_ALIGN_CHECK_EN
            if (misaligned_s) begin
              // Trap: skip the delay slot and stop right away.
              state_d      = PC_HALTED;
              pc_d         = HALT_ADDR;
              active_d     = 1'b0;
              addr_fault_d = 1'b1;
            end else begin
              state_d   = PC_DELAY;
              pending_d = target_s;
              pc_d      = pc_q + PC_STEP;
            end
`else
            state_d   = PC_DELAY;
            pending_d = target_s;
            pc_d      = pc_q + PC_STEP;
`endif
          end
        end
        PC_DELAY: begin
          // Delay slot is issuing; its own redirect_kind is ignored.
          pc_d = pending_q;
          if (pending_q == HALT_ADDR) begin
            state_d  = PC_HALTED;
            active_d = 1'b0;
          end else begin
            state_d = PC_RUN;
          end
        end
        PC_HALTED: begin
          pc_d     = HALT_ADDR;
          active_d = 1'b0;
        end
        default: begin
          // Unreachable encoding: fail safe by stopping the CPU.
          state_d  = PC_HALTED;
          pc_d     = HALT_ADDR;
          active_d = 1'b0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State and address registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= PC_RUN;
      pc_q         <= RESET_VECTOR;
      pending_q    <= 32'h0000_0000;
      active_q     <= 1'b1;
      addr_fault_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pending_q    <= pending_d;
      active_q     <= active_d;
      addr_fault_q <= addr_fault_d;
    end
  end

  assign instr_address = pc_q;
  assign active        = active_q;
  assign addr_fault    = addr_fault_q;

endmodule

// File: tb/tb_mips_cpu_pc_unit.sv
// ----------------------------------------------------------------------------
// tb_mips_cpu_pc_unit
// Self-checking bench: directed scenarios with literal expectations plus a
// randomized run, all compared every cycle against a behavioural model.
// Honors PC_ALIGN_CHECK_EN the same way as the design.
// ----------------------------------------------------------------------------
module tb_mips_cpu_pc_unit;

  localparam logic [31:0] RV = 32'hBFC0_0000;

  logic        clk;
  logic        reset;
  logic        clk_enable;
  logic [1:0]  redirect_kind;
  logic [15:0] branch_imm;
  logic [25:0] jump_index;
  logic [31:0] jr_target;
  logic [31:0] instr_address;
  logic [31:0] link_addr;
  logic        active;
  logic        addr_fault;

  int checks   = 0;
  int failures = 0;

  // Behavioural model: mode 0 = running, 1 = delay slot pending, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc;
  logic [31:0] m_pend;
  logic        m_active;
  logic        m_fault;
  bit          chk_on = 0;

  mips_cpu_pc_unit dut (
    .clk           (clk),
    .reset         (reset),
    .clk_enable    (clk_enable),
    .redirect_kind (redirect_kind),
    .branch_imm    (branch_imm),
    .jump_index    (jump_index),
    .jr_target     (jr_target),
    .instr_address (instr_address),
    .link_addr     (link_addr),
    .active        (active),
    .addr_fault    (addr_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Redirect destination from the architectural rules, in plain arithmetic.
  function automatic logic [31:0] model_target(input logic [31:0] pc, input logic [1:0] k,
                                               input logic [15:0] imm, input logic [25:0] idx,
                                               input logic [31:0] jr);
    logic [31:0] base;
    int          off;
    base = pc + 32'd4;
    off  = 32'(signed'(imm)) * 4;
    if (k == 2'd1)      return base + 32'(off);
    else if (k == 2'd2) return (base & 32'hF000_0000) | (32'(idx) * 32'd4);
    else                return jr;
  endfunction

  task automatic model_edge(input bit rst, input bit en, input logic [1:0] k,
                            input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
    logic [31:0] t;
    if (rst) begin
      m_mode = 0; m_pc = RV; m_pend = 32'd0; m_active = 1'b1; m_fault = 1'b0;
    end else if (en) begin
      if (m_mode == 0) begin
        if (k == 2'd0) begin
          m_pc = m_pc + 32'd4;
        end else begin
          t = model_target(m_pc, k, imm, idx, jr);
`ifdef PC_ALIGN_CHECK_EN
          if (t % 4 != 0) begin
            m_mode = 2; m_pc = 32'd0; m_active = 1'b0; m_fault = 1'b1;
          end else begin
            m_pend = t; m_pc = m_pc + 32'd4; m_mode = 1;
          end
`else
          m_pend = t - (t % 4); m_pc = m_pc + 32'd4; m_mode = 1;
`endif
        end
      end else if (m_mode == 1) begin
        m_pc = m_pend;
        if (m_pend == 32'd0) begin
          m_mode = 2; m_active = 1'b0;
        end else begin
          m_mode = 0;
        end
      end
    end
  endtask

  // One clock: drive inputs, advance model on the edge, settle past the edge.
  task automatic step(input bit rst, input bit en, input logic [1:0] k,
                      input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] jr);
    reset = rst; clk_enable = en; redirect_kind = k;
    branch_imm = imm; jump_index = idx; jr_target = jr;
    @(posedge clk);
    model_edge(rst, en, k, imm, idx, jr);
    chk_on = 1;
    #1;
  endtask

  task automatic none(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 2'd0, 16'd0, 26'd0, 32'd0);
  endtask

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("instr_address", instr_address, m_pc);
      chk("link_addr", link_addr, m_pc + 32'd8);
      chk("active", {31'd0, active}, {31'd0, m_active});
      chk("addr_fault", {31'd0, addr_fault}, {31'd0, m_fault});
    end
  end

  initial begin
    int r;
    logic [1:0]  k;
    logic [31:0] jr;
    reset = 1'b1; clk_enable = 1'b0; redirect_kind = 2'd0;
    branch_imm = 16'd0; jump_index = 26'd0; jr_target = 32'd0;

    // 1: reset (with enable low) then sequential fetch
    step(1, 0, 2'd0, 16'd0, 26'd0, 32'd0);
    chk("t1_reset_pc", instr_address, 32'hBFC0_0000);
    chk("t1_reset_active", {31'd0, active}, 32'd1);
    none(3);
    chk("t1_pc3", instr_address, 32'hBFC0_000C);

    // 2: branch at BFC00008
    step(1, 1, 2'd0, 16'd0, 26'd0, 32'd0);
    none(2);
    chk("t2_link", link_addr, 32'hBFC0_0010);
    step(0, 1, 2'd1, 16'h0003, 26'd0, 32'd0);
    chk("t2_slot", instr_address, 32'hBFC0_000C);
    step(0, 1, 2'd1, 16'h7777, 26'd0, 32'd0);
    chk("t2_target", instr_address, 32'hBFC0_0018);

    // 3: JR to halt address at BFC0002C
    step(1, 1, 2'd0, 16'd0, 26'd0, 32'd0);
    none(11);
    chk("t3_at", instr_address, 32'hBFC0_002C);
    step(0, 1, 2'd3, 16'd0, 26'd0, 32'd0);
    chk("t3_slot", instr_address, 32'hBFC0_0030);
    chk("t3_slot_active", {31'd0, active}, 32'd1);
    step(0, 1, 2'd0, 16'd0, 26'd0, 32'd0);
    chk("t3_halt_pc", instr_address, 32'h0);
    chk("t3_halt_active", {31'd0, active}, 32'd0);
    for (int i = 0; i < 6; i++) step(0, 1, 2'(i % 4), 16'h0004, 26'h1, 32'h100);
    chk("t3_stay_pc", instr_address, 32'h0);

    // 4: negative branch and J target formation
    step(1, 1, 2'd0, 16'd0, 26'd0, 32'd0);
    step(0, 1, 2'd3, 16'd0, 26'd0, 32'h3FFF_FFF0);
    none(1);
    chk("t4_at", instr_address, 32'h3FFF_FFF0);
    step(0, 1, 2'd1, 16'hFFFC, 26'd0, 32'd0);
    chk("t4_slot", instr_address, 32'h3FFF_FFF4);
    none(1);
    chk("t4_neg_branch", instr_address, 32'h3FFF_FFE4);
    step(1, 1, 2'd0, 16'd0, 26'd0, 32'd0);
    step(0, 1, 2'd2, 16'd0, 26'h0000010, 32'd0);
    chk("t4_j_slot", instr_address, 32'hBFC0_0004);
    none(1);
    chk("t4_j_target", instr_address, 32'hB000_0040);

    // wrap past the top of memory is not a halt
    step(1, 1, 2'd0, 16'd0, 26'd0, 32'd0);
    step(0, 1, 2'd3, 16'd0, 26'd0, 32'hFFFF_FFFC);
    none(2);
    chk("wrap_pc", instr_address, 32'h0);
    chk("wrap_active", {31'd0, active}, 32'd1);

    // 5: freeze in delay slot, then reset in delay slot
    step(1, 1, 2'd0, 16'd0, 26'd0, 32'd0);
    step(0, 1, 2'd1, 16'h0003, 26'd0, 32'd0);
    for (int i = 0; i < 4; i++) step(0, 0, 2'd2, 16'h0, 26'h3, 32'h40);
    chk("t5_frozen", instr_address, 32'hBFC0_0004);
    none(1);
    chk("t5_applied", instr_address, 32'hBFC0_0010);
    step(0, 1, 2'd1, 16'h0003, 26'd0, 32'd0);
    step(1, 1, 2'd0, 16'd0, 26'd0, 32'd0);
    chk("t5_reset_delay", instr_address, 32'hBFC0_0000);
    none(2);
    chk("t5_redirect_lost", instr_address, 32'hBFC0_0008);

    // 6: misaligned register target
    step(1, 1, 2'd0, 16'd0, 26'd0, 32'd0);
    step(0, 1, 2'd3, 16'd0, 26'd0, 32'hBFC0_0022);
`ifdef PC_ALIGN_CHECK_EN
    chk("t6_fault", {31'd0, addr_fault}, 32'd1);
    chk("t6_active", {31'd0, active}, 32'd0);
    chk("t6_pc", instr_address, 32'h0);
`else
    chk("t6_slot", instr_address, 32'hBFC0_0004);
    none(1);
    chk("t6_aligned", instr_address, 32'hBFC0_0020);
    chk("t6_nofault", {31'd0, addr_fault}, 32'd0);
`endif

    // Randomized run against the model
    step(1, 1, 2'd0, 16'd0, 26'd0, 32'd0);
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 99);
      k = (r < 65) ? 2'd0 : 2'($urandom_range(1, 3));
      case ($urandom_range(0, 9))
        0:       jr = 32'd0;
        1:       jr = $urandom;
        default: jr = $urandom & 32'hFFFF_FFFC;
      endcase
      step((r < 2) || (m_mode == 2 && $urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) != 0), k, 16'($urandom), 26'($urandom), jr);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
